dbpsk_receiver: RTL

//   Receive-side counterpart of the tag TX chain (data_source -> whitening -> dbpsk_modulator).

---
 rtl/dbpsk_pkg.sv | 14 +
 rtl/dbpsk_rx_descrambler.sv | 31 +++
 rtl/dbpsk_receiver.sv | 95 +++++++++
 3 files changed

// File: rtl/dbpsk_pkg.sv
// dbpsk_pkg: shared state encoding, SFD default and whitening taps for the DBPSK chain
package dbpsk_pkg;
  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    SFD_SEARCH = 2'd1,
    PAYLOAD    = 2'd2
  } rx_state_t;
  localparam logic [15:0] SFD_DEFAULT = 16'hF3A0;
  localparam int TAP_A = 3;
  localparam int TAP_B = 6;
  function automatic logic scr_bit(input logic [6:0] sreg, input logic d);
    return d ^ sreg[TAP_A] ^ sreg[TAP_B];
  endfunction
endpackage

// File: rtl/dbpsk_rx_descrambler.sv
// dbpsk_rx_descrambler: differential decode plus x^7+x^4+1 self-synchronising descramble
module dbpsk_rx_descrambler
  import dbpsk_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic in_bit,
  input  logic in_valid,
  output logic out_bit,
  output logic out_valid
);
  logic prev_sym;
  logic [6:0] sreg;
  logic d;
  // Output is combinational so the receiver adds only its own register stage of latency
  assign d = in_bit ^ prev_sym;
  assign out_bit = scr_bit(sreg, d);
  assign out_valid = in_valid & ~clear;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      prev_sym <= 1'b0;
      sreg <= '0;
    end else if (clear) begin
      prev_sym <= 1'b0;
      sreg <= '0;
    end else if (in_valid) begin
      prev_sym <= in_bit;
      sreg <= {sreg[5:0], d};
    end
endmodule

// File: rtl/dbpsk_receiver.sv
// dbpsk_receiver: DBPSK loopback receiver - SYNC hunt, SFD match and payload byte assembly
module dbpsk_receiver
  import dbpsk_pkg::*;
#(
  parameter int          SYNC_MIN      = 16,
  parameter logic [15:0] SFD_PATTERN   = SFD_DEFAULT,
  parameter int          SFD_TIMEOUT   = 64,
  parameter int          PAYLOAD_BYTES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       sample_bit,
  input  logic       sample_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy
);
  localparam int OW = $clog2(SYNC_MIN + 1);
  localparam int BW = $clog2(SFD_TIMEOUT + 1);
  rx_state_t state, state_nxt;
  logic b, bv;
  logic [OW-1:0] ones_cnt;
  logic [BW-1:0] bit_cnt;
  logic [15:0] sfd_sr, sfd_nxt;
  logic [6:0] byte_sr;
  logic [7:0] byte_cnt;
  logic [2:0] bitpos;
  logic sync_hit, sfd_hit, timeout, byte_end, last;
  logic fs_nxt, dv_nxt, fd_nxt;
  dbpsk_rx_descrambler u_desc (
    .clock    (clock),
    .reset    (reset),
    .clear    (~enable),
    .in_bit   (sample_bit),
    .in_valid (sample_valid),
    .out_bit  (b),
    .out_valid(bv)
  );
  assign sfd_nxt  = {b, sfd_sr[15:1]};
  assign sync_hit = bv && state == HUNT && b && ones_cnt >= OW'(SYNC_MIN - 1);
  assign sfd_hit  = bv && state == SFD_SEARCH && sfd_nxt == SFD_PATTERN;
  assign timeout  = bv && state == SFD_SEARCH && !sfd_hit && bit_cnt >= BW'(SFD_TIMEOUT - 1);
  assign byte_end = bv && state == PAYLOAD && bitpos == 3'd7;
  assign last     = byte_end && byte_cnt == 8'(PAYLOAD_BYTES - 1);
  assign busy     = state == SFD_SEARCH || state == PAYLOAD;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= HUNT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = !enable ? HUNT :
                sync_hit ? SFD_SEARCH :
                sfd_hit ? PAYLOAD :
                (timeout || last) ? HUNT : state;
  end
  always_comb begin
    fs_nxt = enable && sfd_hit;
    dv_nxt = enable && byte_end;
    fd_nxt = enable && last;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ones_cnt <= '0;
      bit_cnt <= '0;
      sfd_sr <= '0;
      byte_sr <= '0;
      byte_cnt <= '0;
      bitpos <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_valid <= dv_nxt;
      frame_start <= fs_nxt;
      frame_done <= fd_nxt;
      if (!enable) begin
        ones_cnt <= '0;
        bit_cnt <= '0;
        sfd_sr <= '0;
        byte_cnt <= '0;
        bitpos <= '0;
      end else if (bv) begin
        ones_cnt <= (state == HUNT && b) ? (ones_cnt == OW'(SYNC_MIN) ? ones_cnt : ones_cnt + 1'b1) : '0;
        sfd_sr <= state == SFD_SEARCH ? sfd_nxt : '0;
        bit_cnt <= state == SFD_SEARCH ? (bit_cnt == BW'(SFD_TIMEOUT) ? bit_cnt : bit_cnt + 1'b1) : '0;
        bitpos <= state == PAYLOAD ? bitpos + 1'b1 : '0;
        byte_cnt <= state != PAYLOAD ? '0 : byte_end ? byte_cnt + 1'b1 : byte_cnt;
        if (state == PAYLOAD) byte_sr <= {b, byte_sr[6:1]};
        if (byte_end) data_out <= {b, byte_sr};
      end
    end
endmodule
